// File: rtl/pc_unit_16_bit_if.sv
// Control and observation bundle for the program-counter stage.
// The decode/ALU side drives the controls; the PC stage returns the fetch address and status.
interface pc_unit_16_bit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             halt;
  logic             stall;
  logic             jump;
  logic [WIDTH-1:0] jump_addr;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_off;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_inc;
  logic             running;
  logic [15:0]      upd_count;

  modport master (
    output start, halt, stall, jump, jump_addr, branch_taken, branch_off,
    input  pc, pc_plus_inc, running, upd_count
  );

  modport slave (
    input  start, halt, stall, jump, jump_addr, branch_taken, branch_off,
    output pc, pc_plus_inc, running, upd_count
  );
endinterface

// File: rtl/pc_unit_16_bit.sv
// Program-counter stage: next-PC selection (increment, relative branch, absolute jump),
// run/halt sequencing and a saturating count of PC updates for bring-up.
//
// state | meaning
// IDLE  | out of reset, waiting for start; pc held
// RUN   | fetching; pc advances every edge unless halt/stall
// HALT  | fetch stopped by halt; start resumes at the held pc
// (encoding 11 is unused and returns to IDLE on the next edge)
module pc_unit_16_bit #(
  parameter int                   WIDTH    = 16,
  parameter logic [WIDTH-1:0]     RESET_PC = '0,
  parameter int unsigned          INC      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pc_unit_16_bit_if.slave        bus
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc, pc_nxt;
  logic [WIDTH-1:0] pc_inc;
  logic [15:0]      upd_count;
  logic             upd;

  assign pc_inc = pc + INC_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      upd_count <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (upd && (upd_count != 16'hFFFF))
        upd_count <= upd_count + 16'd1;
    end
  end

  // halt > stall > jump > branch_taken > increment; only RUN moves the pc
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    upd       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start)
          state_nxt = RUN;
      end
      RUN: begin
        if (bus.halt) begin
          state_nxt = HALT;
        end else if (!bus.stall) begin
          upd = 1'b1;
          if (bus.jump)
            pc_nxt = bus.jump_addr;
          else if (bus.branch_taken)
            pc_nxt = pc_inc + bus.branch_off;
          else
            pc_nxt = pc_inc;
        end
      end
      HALT: begin
        if (bus.start)
          state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.pc          = pc;
  assign bus.pc_plus_inc = pc_inc;
  assign bus.running     = (state == RUN);
  assign bus.upd_count   = upd_count;

endmodule

// File: tb/tb_pc_unit_16_bit.sv
// Scoreboard bench for pc_unit_16_bit: directed steps push hand-computed expectations,
// a monitor pops and compares them just after each rising edge (or on an async-reset probe).
module tb_pc_unit_16_bit;

  logic clk;
  logic rst_n;

  pc_unit_16_bit_if #(.WIDTH(16)) bus();

  pc_unit_16_bit #(.WIDTH(16), .RESET_PC(16'h0000), .INC(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic [15:0] ppi;
    logic        run;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event chk_now;

  task automatic push_exp(input string nm, input logic [15:0] epc,
                          input logic erun, input logic [15:0] ecnt);
    exp_t e;
    e.name = nm;
    e.pc   = epc;
    e.ppi  = epc + 16'd1;
    e.run  = erun;
    e.cnt  = ecnt;
    q.push_back(e);
  endtask

  // Drive one cycle of controls; expectation is the state just after the next rising edge.
  task automatic step(input string nm, input logic st, input logic hl, input logic sl,
                      input logic jp, input logic [15:0] ja, input logic br,
                      input logic [15:0] bo, input logic [15:0] epc,
                      input logic erun, input logic [15:0] ecnt);
    @(negedge clk);
    bus.start        = st;
    bus.halt         = hl;
    bus.stall        = sl;
    bus.jump         = jp;
    bus.jump_addr    = ja;
    bus.branch_taken = br;
    bus.branch_off   = bo;
    push_exp(nm, epc, erun, ecnt);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or chk_now);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (bus.pc !== e.pc || bus.pc_plus_inc !== e.ppi ||
            bus.running !== e.run || bus.upd_count !== e.cnt) begin
          errors++;
          $display("FAIL %s: got pc=%h ppi=%h run=%b cnt=%h, expected pc=%h ppi=%h run=%b cnt=%h",
                   e.name, bus.pc, bus.pc_plus_inc, bus.running, bus.upd_count,
                   e.pc, e.ppi, e.run, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.halt         = 1'b0;
    bus.stall        = 1'b0;
    bus.jump         = 1'b0;
    bus.jump_addr    = 16'h0000;
    bus.branch_taken = 1'b0;
    bus.branch_off   = 16'h0000;

    // reset state, observed with no edge required
    #3;
    push_exp("reset_state", 16'h0000, 1'b0, 16'h0000);
    -> chk_now;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //   name             st   hl   sl   jp   ja        br   bo        pc        run  cnt
    step("idle_ignores",  1'b0,1'b0,1'b0,1'b1,16'h0040,1'b1,16'h0003,16'h0000,1'b0,16'h0000);
    // 1: start for one cycle, then four plain increments
    step("start",         1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,1'b1,16'h0000);
    for (int i = 1; i <= 4; i++)
      step("inc_seq",     1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'(i),  1'b1,16'(i));
    // 2: relative branches, positive then negative offset
    step("jump_0010",     1'b0,1'b0,1'b0,1'b1,16'h0010,1'b0,16'h0000,16'h0010,1'b1,16'h0005);
    step("branch_pos",    1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,16'h0005,16'h0016,1'b1,16'h0006);
    step("branch_neg",    1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,16'hFFF0,16'h0007,1'b1,16'h0007);
    // 3: jump beats branch; stall beats jump
    step("jump_0020",     1'b0,1'b0,1'b0,1'b1,16'h0020,1'b0,16'h0000,16'h0020,1'b1,16'h0008);
    step("jump_over_br",  1'b0,1'b0,1'b0,1'b1,16'h0100,1'b1,16'h0005,16'h0100,1'b1,16'h0009);
    step("stall_hold",    1'b0,1'b0,1'b1,1'b1,16'h0200,1'b0,16'h0000,16'h0100,1'b1,16'h0009);
    // 4: wrap at the top of the address space
    step("jump_ffff",     1'b0,1'b0,1'b0,1'b1,16'hFFFF,1'b0,16'h0000,16'hFFFF,1'b1,16'h000A);
    step("inc_wrap",      1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,1'b1,16'h000B);
    step("branch_wrap",   1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,16'hFFFC,16'hFFFD,1'b1,16'h000C);
    // 5: halt freezes pc despite jump/branch, start resumes at the held pc
    step("jump_0008",     1'b0,1'b0,1'b0,1'b1,16'h0008,1'b0,16'h0000,16'h0008,1'b1,16'h000D);
    step("halt",          1'b0,1'b1,1'b0,1'b1,16'h0055,1'b1,16'h0002,16'h0008,1'b0,16'h000D);
    for (int i = 0; i < 5; i++)
      step("halt_hold",   1'b0,1'b0,1'b0,1'b1,16'h0055,1'b1,16'h0002,16'h0008,1'b0,16'h000D);
    step("resume",        1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0008,1'b1,16'h000D);
    step("resume_inc",    1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0009,1'b1,16'h000E);
    step("start_in_run",  1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h000A,1'b1,16'h000F);
    // 6: asynchronous reset mid-RUN, then edges while held in reset
    step("jump_0033",     1'b0,1'b0,1'b0,1'b1,16'h0033,1'b0,16'h0000,16'h0033,1'b1,16'h0010);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp("async_reset", 16'h0000, 1'b0, 16'h0000);
    -> chk_now;
    step("rst_held_a",    1'b1,1'b0,1'b0,1'b1,16'h0077,1'b0,16'h0000,16'h0000,1'b0,16'h0000);
    step("rst_held_b",    1'b0,1'b0,1'b0,1'b0,16'h0000,1'b1,16'h0004,16'h0000,1'b0,16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step("restart",       1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,1'b1,16'h0000);
    step("restart_inc",   1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0001,1'b1,16'h0001);
    // free-run 65533 unchecked increments to reach the counter ceiling
    repeat (65533) @(negedge clk);
    step("cnt_ffff",      1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'hFFFF,1'b1,16'hFFFF);
    step("cnt_saturate",  1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,1'b1,16'hFFFF);

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
